amp_bcd_entry: RTL and testbench

AMP_BCD_ENTRY -- requirements
Module: amp_bcd_entry

---
 rtl/amp_bcd_entry_pkg.sv | 35 +++
 rtl/amp_bcd_entry_if.sv | 23 ++
 rtl/amp_bcd_entry_bcd_to_bin.sv | 49 ++++
 rtl/amp_bcd_entry.sv | 136 +++++++++++++
 tb/tb_amp_bcd_entry.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/amp_bcd_entry_pkg.sv
// Shared constants, types and the reverse double-dabble step for amp_bcd_entry.
package amp_bcd_entry_pkg;

  localparam int         ONE_PERCENT = 163;
  localparam logic [3:0] ACTIVE_AMP  = 4'h2;
  localparam int         MAX_PCT     = 100;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CONVERT,
    MULT,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Work word is {hundreds, tens, units, bin[6:0]}; one step halves the BCD part.
  function automatic logic [18:0] rdd_step(input logic [18:0] w);
    logic [18:0] s;
    s = w >> 1;
    for (int d = 0; d < 3; d++) begin
      if (s[7+4*d +: 4] >= 4'd8) begin
        s[7+4*d +: 4] = s[7+4*d +: 4] - 4'd3;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/amp_bcd_entry_if.sv
// Menu-side bus of the amplitude entry block: request, BCD value, status and results.
interface amp_bcd_entry_if;
  import amp_bcd_entry_pkg::*;

  logic        load;
  logic [3:0]  active;
  bcd_t        bcdIn;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  ampBIN;
  logic [13:0] ampDDS;

  modport master (
    output load, active, bcdIn,
    input  busy, done, error, ampBIN, ampDDS
  );

  modport slave (
    input  load, active, bcdIn,
    output busy, done, error, ampBIN, ampDDS
  );
endinterface

// File: rtl/amp_bcd_entry_bcd_to_bin.sv
// Three-digit BCD to 7-bit binary converter, 7 reverse double-dabble steps.
module bcd_to_bin
  import amp_bcd_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  bcd_t       i_bcd,
  output logic       o_busy,
  output logic       o_done,
  output logic [6:0] o_bin
);

  logic [18:0] r_work;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  // The start edge performs the first step, so the result is ready after 7 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_work <= rdd_step({i_bcd, 7'd0});
        r_cnt  <= 3'd1;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_work <= rdd_step(r_work);
        if (r_cnt == 3'd6) begin
          r_cnt  <= 3'd0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bin  = r_work[6:0];

endmodule

// File: rtl/amp_bcd_entry.sv
// Amplitude entry: validates a BCD percent, converts it and scales it to an AD9954 word.
// Optional macro AMP_CLAMP_EN clamps valid-digit values above 100 to 100 instead of erroring.
module amp_bcd_entry #(
  parameter int         ONE_PERCENT = amp_bcd_entry_pkg::ONE_PERCENT,
  parameter logic [3:0] ACTIVE_AMP  = amp_bcd_entry_pkg::ACTIVE_AMP
) (
  input  logic             clk,
  input  logic             rst_n,
  amp_bcd_entry_if.slave   bus
);
  import amp_bcd_entry_pkg::*;

  localparam logic [7:0] OP8 = ONE_PERCENT[7:0];

  state_t      r_state;
  bcd_t        r_bcd;
  logic        r_start;
  logic [6:0]  r_bin;
  logic [13:0] r_acc;
  logic [13:0] r_mcand;
  logic [2:0]  r_mul_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [6:0]  r_amp_bin;
  logic [13:0] r_amp_dds;

  logic        w_conv_busy;
  logic        w_conv_done;
  logic [6:0]  w_bin;
  logic        w_digit_bad;
  logic        w_over;
  logic [13:0] w_acc_next;

  bcd_to_bin u_bcd_to_bin (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_start),
    .i_bcd   (r_bcd),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bin   (w_bin)
  );

  assign w_digit_bad = (r_bcd.hundreds > 4'd9) || (r_bcd.tens > 4'd9) || (r_bcd.units > 4'd9);
  assign w_over      = (r_bcd.hundreds > 4'd1) ||
                       ((r_bcd.hundreds == 4'd1) && ((r_bcd.tens != 4'd0) || (r_bcd.units != 4'd0)));
  assign w_acc_next  = r_acc + (OP8[r_mul_cnt] ? r_mcand : 14'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bcd     <= '0;
      r_start   <= 1'b0;
      r_bin     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mul_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_amp_bin <= '0;
      r_amp_dds <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load && (bus.active == ACTIVE_AMP)) begin
            r_bcd   <= bus.bcdIn;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_digit_bad) begin
            r_state <= ERR;
          end else if (w_over) begin
`ifdef AMP_CLAMP_EN
            r_bcd   <= 12'h100;
            r_start <= 1'b1;
            r_state <= CONVERT;
`else
            r_state <= ERR;
`endif
          end else begin
            r_start <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          // First multiply step (multiplier bit 0) happens on the hand-over edge.
          if (w_conv_done && !w_conv_busy) begin
            r_bin     <= w_bin;
            r_acc     <= OP8[0] ? {7'd0, w_bin} : 14'd0;
            r_mcand   <= {6'd0, w_bin, 1'b0};
            r_mul_cnt <= 3'd1;
            r_state   <= MULT;
          end
        end
        MULT: begin
          r_acc     <= w_acc_next;
          r_mcand   <= r_mcand << 1;
          r_mul_cnt <= r_mul_cnt + 3'd1;
          if (r_mul_cnt == 3'd7) begin
            r_amp_dds <= w_acc_next;
            r_amp_bin <= r_bin;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.error  = r_error;
  assign bus.ampBIN = r_amp_bin;
  assign bus.ampDDS = r_amp_dds;

endmodule

// File: tb/tb_amp_bcd_entry.sv
// Self-checking bench for amp_bcd_entry: vector table plus reset and overlap sequences.
module tb_amp_bcd_entry;
  import amp_bcd_entry_pkg::*;

  typedef struct {
    logic [11:0] bcd;
    logic [3:0]  act;
    int          kind;   // 0 ignored, 1 done, 2 error
    int          bin;
    int          dds;
  } vec_t;

  typedef struct {
    int kind;
    int bin;
    int dds;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   last_bin;
  int   last_dds;
  exp_t sb_q[$];
  vec_t vecs[10];

  amp_bcd_entry_if bus();

  amp_bcd_entry #(
    .ONE_PERCENT (163),
    .ACTIVE_AMP  (4'h2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [11:0] bcd, input logic [3:0] act,
                         input int kind, input int pbin, input int pdds);
    exp_t e;
    int done_k, err_k, n_done, n_err, both, busy_gap, busy_seen, got_bin, got_dds;
    e.kind = kind;
    if (kind == 1) begin
      e.bin = pbin;
      e.dds = pdds;
    end else begin
      e.bin = last_bin;
      e.dds = last_dds;
    end
    sb_q.push_back(e);
    bus.bcdIn  = bcd;
    bus.active = act;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    done_k = -1; err_k = -1; n_done = 0; n_err = 0; both = 0; busy_gap = 0; busy_seen = 0;
    got_bin = -1; got_dds = -1;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) begin
        n_done++;
        if (done_k < 0) begin
          done_k  = k;
          got_bin = int'(bus.ampBIN);
          got_dds = int'(bus.ampDDS);
        end
      end
      if (bus.error) begin
        n_err++;
        if (err_k < 0) err_k = k;
      end
      if (bus.done && bus.error) both++;
      if (k < 16 && !bus.busy) busy_gap++;
      if (bus.busy) busy_seen++;
      @(negedge clk);
    end
    if (done_k < 0) begin
      got_bin = int'(bus.ampBIN);
      got_dds = int'(bus.ampDDS);
    end
    e = sb_q.pop_front();
    if (e.kind == 1) begin
      chk({tag, "_done_cycle"}, done_k, 16);
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_busy_16"}, busy_gap, 0);
      chk({tag, "_no_error"}, n_err, 0);
      last_bin = e.bin;
      last_dds = e.dds;
    end else if (e.kind == 2) begin
      chk({tag, "_err_cycle"}, err_k, 2);
      chk({tag, "_err_count"}, n_err, 1);
      chk({tag, "_no_done"}, n_done, 0);
    end else begin
      chk({tag, "_busy_never"}, busy_seen, 0);
      chk({tag, "_no_pulse"}, n_done + n_err, 0);
    end
    chk({tag, "_overlap"}, both, 0);
    chk({tag, "_ampBIN"}, got_bin, e.bin);
    chk({tag, "_ampDDS"}, got_dds, e.dds);
    $display("txn %s bcd=%03h active=%0h kind=%0d ampBIN=%0d ampDDS=%0d", tag, bcd, act, e.kind,
             got_bin, got_dds);
  endtask

  initial begin
    int n_done, n_err, k_done;
    checks = 0; failures = 0; last_bin = 0; last_dds = 0;

    vecs[0] = '{12'h050, 4'h2, 1, 50, 8150};
    vecs[1] = '{12'h100, 4'h2, 1, 100, 16300};
    vecs[2] = '{12'h000, 4'h2, 1, 0, 0};
    vecs[3] = '{12'h099, 4'h2, 1, 99, 16137};
    vecs[4] = '{12'h0A5, 4'h2, 2, 0, 0};
`ifdef AMP_CLAMP_EN
    vecs[5] = '{12'h101, 4'h2, 1, 100, 16300};
    vecs[8] = '{12'h200, 4'h2, 1, 100, 16300};
`else
    vecs[5] = '{12'h101, 4'h2, 2, 0, 0};
    vecs[8] = '{12'h200, 4'h2, 2, 0, 0};
`endif
    vecs[6] = '{12'h050, 4'h1, 0, 0, 0};
    vecs[7] = '{12'h07F, 4'h2, 2, 0, 0};
    vecs[9] = '{12'h001, 4'h2, 1, 1, 163};

    rst_n = 1'b0; bus.load = 1'b0; bus.active = 4'h0; bus.bcdIn = 12'h000;
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_error", int'(bus.error), 0);
    chk("reset_ampBIN", int'(bus.ampBIN), 0);
    chk("reset_ampDDS", int'(bus.ampDDS), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].act, vecs[i].kind, vecs[i].bin,
              vecs[i].dds);
    end

    // Second load at N+5 with a different value and menu: must be dropped.
    bus.bcdIn = 12'h025; bus.active = 4'h2; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n_done = 0; n_err = 0; k_done = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) begin
        bus.load = 1'b1; bus.bcdIn = 12'h075;
      end
      if (k == 5) begin
        bus.load = 1'b0; bus.active = 4'h1;
      end
      if (bus.done) begin
        n_done++;
        if (k_done < 0) k_done = k;
      end
      if (bus.error) n_err++;
      @(negedge clk);
    end
    chk("overlap_done_cycle", k_done, 16);
    chk("overlap_done_count", n_done + n_err, 1);
    chk("overlap_ampBIN", int'(bus.ampBIN), 25);
    chk("overlap_ampDDS", int'(bus.ampDDS), 4075);
    last_bin = 25; last_dds = 4075;
    $display("txn overlap bcd=025 ampBIN=%0d ampDDS=%0d", bus.ampBIN, bus.ampDDS);
    bus.active = 4'h2;

    // Reset at N+10 while multiplying: everything clears, no pulse follows.
    bus.bcdIn = 12'h080; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_ampBIN", int'(bus.ampBIN), 0);
    chk("midrst_ampDDS", int'(bus.ampDDS), 0);
    n_done = 0; n_err = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (bus.done) n_done++;
      if (bus.error) n_err++;
    end
    chk("midrst_no_pulse", n_done + n_err, 0);
    $display("txn midrst bcd=080 ampBIN=%0d ampDDS=%0d", bus.ampBIN, bus.ampDDS);
    last_bin = 0; last_dds = 0;
    run_vec("post_rst", 12'h042, 4'h2, 1, 42, 6846);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
